// File: rtl/core_step_controller.sv
// ---------------------------------------------------------------------------
// core_step_controller
//
// Run-control block that sits between a host command stream and a RISC-V
// core. It gates the core clock, holds the core in reset, single-steps it,
// watches the RVFI retirement port for breakpoints and traps, and keeps a
// small trace FIFO of retired {pc, insn} pairs that the host can read back.
//
// Parameters
//   CLK_FREQ      system clock frequency in Hz (informational)
//   TRACE_DEPTH   trace FIFO entries, power of two, 2..256
//   CYCLE_WIDTH   width of the STEP cycle count taken from cmd_arg (1..32)
//   RESET_CYCLES  number of clk cycles reset_core is held (>= 1)
//
// Ports
//   clk, reset            clock and asynchronous active-low reset
//   cmd_valid/ready       host command handshake
//   cmd_op, cmd_arg       opcode (NOP, RESET_CORE, RUN, STEP, HALT, SET_BP,
//                         READ_TRACE, STATUS) and its 32-bit argument
//   rsp_valid/ready/data  response stream, one beat per command
//                         (two beats for READ_TRACE)
//   clk_core_en           core clock enable for an external gating cell
//   reset_core            active-high core reset
//   rvfi_*                core retirement trace inputs
// ---------------------------------------------------------------------------
module core_step_controller #(
  parameter int unsigned CLK_FREQ     = 25000000,
  parameter int unsigned TRACE_DEPTH  = 16,
  parameter int unsigned CYCLE_WIDTH  = 32,
  parameter int unsigned RESET_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_arg,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        clk_core_en,
  output logic        reset_core,
  input  logic        rvfi_valid,
  input  logic        rvfi_trap,
  input  logic [31:0] rvfi_pc_rdata,
  input  logic [31:0] rvfi_insn
);

  localparam int unsigned AW = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
  localparam int unsigned CW = $clog2(TRACE_DEPTH + 1);

  localparam logic [2:0] OP_NOP        = 3'd0;
  localparam logic [2:0] OP_RESET_CORE = 3'd1;
  localparam logic [2:0] OP_RUN        = 3'd2;
  localparam logic [2:0] OP_STEP       = 3'd3;
  localparam logic [2:0] OP_HALT       = 3'd4;
  localparam logic [2:0] OP_SET_BP     = 3'd5;
  localparam logic [2:0] OP_READ_TRACE = 3'd6;
  localparam logic [2:0] OP_STATUS     = 3'd7;

  localparam logic [31:0] RSP_OK  = 32'h0000_0000;
  localparam logic [31:0] RSP_ERR = 32'hFFFF_FFFF;

  // Reject parameter sets the FIFO pointer arithmetic cannot handle.
  if (TRACE_DEPTH < 2 || TRACE_DEPTH > 256 ||
      (TRACE_DEPTH & (TRACE_DEPTH - 1)) != 0 ||
      CYCLE_WIDTH < 1 || CYCLE_WIDTH > 32 ||
      RESET_CYCLES < 1 || CLK_FREQ == 0) begin : g_paramCheck
    $error("core_step_controller: illegal parameter set");
  end

  typedef enum logic [1:0] {
    RESETTING = 2'd0,
    HALTED    = 2'd1,
    RUNNING   = 2'd2,
    STEPPING  = 2'd3
  } state_t;

  state_t        r_state;
  logic [31:0]   r_count;
  logic          r_rspValid;
  logic [31:0]   r_rspData;
  logic          r_pend2;
  logic [31:0]   r_beat2;
  logic          r_bpEn;
  logic [31:0]   r_bpAddr;
  logic          r_bpHit;
  logic          r_trapHit;
  logic          r_overflow;
  logic [63:0]   r_mem [TRACE_DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [CW-1:0] r_fifoCount;

  state_t        w_nextState;
  logic [31:0]   w_nextCount;
  logic [31:0]   w_stepN;
  logic [31:0]   w_rspWord;
  logic [31:0]   w_beat2Word;
  logic          w_isTwoBeat;
  logic          w_enterReset;
  logic          w_statusRead;
  logic          w_bpLoad;
  logic          w_accept;
  logic          w_inRun;
  logic          w_fifoEmpty;
  logic          w_fifoFull;
  logic [63:0]   w_head;
  logic          w_trapEvt;
  logic          w_bpEvt;
  logic          w_pop;
  logic          w_push;
  logic          w_dropEvt;
  logic [7:0]    w_count8;

  assign cmd_ready   = (r_state != RESETTING) && !r_rspValid && !r_pend2;
  assign rsp_valid   = r_rspValid;
  assign rsp_data    = r_rspData;
  assign reset_core  = (r_state == RESETTING);
  // The core clock runs in every state except HALTED, including RESETTING
  // so the core actually sees its reset.
  assign clk_core_en = (r_state != HALTED);

  assign w_accept    = cmd_valid && cmd_ready;
  assign w_inRun     = (r_state == RUNNING) || (r_state == STEPPING);
  assign w_fifoEmpty = (r_fifoCount == '0);
  assign w_fifoFull  = (r_fifoCount == CW'(TRACE_DEPTH));
  assign w_head      = r_mem[r_rdPtr];
  assign w_count8    = 8'(r_fifoCount);
  assign w_trapEvt   = w_inRun && rvfi_valid && rvfi_trap;
  assign w_bpEvt     = w_inRun && rvfi_valid && r_bpEn && (rvfi_pc_rdata == r_bpAddr);
  assign w_pop       = w_accept && (cmd_op == OP_READ_TRACE) && !w_fifoEmpty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign w_push      = rvfi_valid && (r_state != RESETTING) && (!w_fifoFull || w_pop);
  assign w_dropEvt   = rvfi_valid && (r_state != RESETTING) && w_fifoFull && !w_pop;

  // STEP count is the low CYCLE_WIDTH bits of the argument, zero-extended.
  always_comb begin
    w_stepN = '0;
    w_stepN[CYCLE_WIDTH-1:0] = cmd_arg[CYCLE_WIDTH-1:0];
  end

  // Next-state and command decode. Countdowns run first, then accepted
  // commands, then breakpoint/trap halts, and RESET_CORE overrides all.
  always_comb begin
    w_nextState  = r_state;
    w_nextCount  = r_count;
    w_rspWord    = RSP_OK;
    w_beat2Word  = RSP_ERR;
    w_isTwoBeat  = 1'b0;
    w_enterReset = 1'b0;
    w_statusRead = 1'b0;
    w_bpLoad     = 1'b0;

    case (r_state)
      RESETTING, STEPPING: begin
        if (r_count <= 32'd1) begin
          w_nextState = HALTED;
        end else begin
          w_nextCount = r_count - 32'd1;
        end
      end
      default: ;
    endcase

    if (w_accept) begin
      case (cmd_op)
        OP_NOP: ;
        OP_RESET_CORE: w_enterReset = 1'b1;
        OP_RUN: begin
          if (r_state == HALTED) w_nextState = RUNNING;
          else                   w_rspWord   = RSP_ERR;
        end
        OP_STEP: begin
          if (r_state != HALTED) begin
            w_rspWord = RSP_ERR;
          end else if (w_stepN != 32'd0) begin
            w_nextState = STEPPING;
            w_nextCount = w_stepN;
          end
        end
        OP_HALT: w_nextState = HALTED;
        OP_SET_BP: begin
          if (r_state == HALTED) w_bpLoad  = 1'b1;
          else                   w_rspWord = RSP_ERR;
        end
        OP_READ_TRACE: begin
          w_isTwoBeat = 1'b1;
          if (!w_fifoEmpty) begin
            w_rspWord   = w_head[63:32];
            w_beat2Word = w_head[31:0];
          end else begin
            w_rspWord   = RSP_ERR;
            w_beat2Word = RSP_ERR;
          end
        end
        OP_STATUS: begin
          w_statusRead = 1'b1;
          w_rspWord    = {16'b0, w_count8, 3'b0, r_trapHit, r_overflow, r_bpHit, r_state};
        end
        default: ;
      endcase
    end

    if (w_trapEvt || w_bpEvt) begin
      w_nextState = HALTED;
    end

    if (w_enterReset) begin
      w_nextState = RESETTING;
      w_nextCount = 32'(RESET_CYCLES);
    end
  end

  // State register and the shared reset/step countdown.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RESETTING;
      r_count <= 32'(RESET_CYCLES);
    end else begin
      r_state <= w_nextState;
      r_count <= w_nextCount;
    end
  end

  // Response stream, breakpoint registers, sticky flags and FIFO pointers.
  // Flag set events win over a same-cycle STATUS clear so none are lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rspValid  <= 1'b0;
      r_rspData   <= '0;
      r_pend2     <= 1'b0;
      r_beat2     <= '0;
      r_bpEn      <= 1'b0;
      r_bpAddr    <= '0;
      r_bpHit     <= 1'b0;
      r_trapHit   <= 1'b0;
      r_overflow  <= 1'b0;
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_fifoCount <= '0;
    end else begin
      if (r_rspValid && rsp_ready) begin
        if (r_pend2) begin
          r_rspData <= r_beat2;
          r_pend2   <= 1'b0;
        end else begin
          r_rspValid <= 1'b0;
        end
      end
      if (w_accept) begin
        r_rspValid <= 1'b1;
        r_rspData  <= w_rspWord;
        r_pend2    <= w_isTwoBeat;
        r_beat2    <= w_beat2Word;
      end

      if (w_bpLoad) begin
        if (cmd_arg == 32'hFFFF_FFFF) begin
          r_bpEn <= 1'b0;
        end else begin
          r_bpEn   <= 1'b1;
          r_bpAddr <= cmd_arg;
        end
      end

      if (w_statusRead) begin
        r_bpHit    <= 1'b0;
        r_trapHit  <= 1'b0;
        r_overflow <= 1'b0;
      end
      if (w_bpEvt)   r_bpHit    <= 1'b1;
      if (w_trapEvt) r_trapHit  <= 1'b1;
      if (w_dropEvt) r_overflow <= 1'b1;

      if (w_enterReset) begin
        r_bpHit     <= 1'b0;
        r_trapHit   <= 1'b0;
        r_overflow  <= 1'b0;
        r_wrPtr     <= '0;
        r_rdPtr     <= '0;
        r_fifoCount <= '0;
      end else begin
        if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
        if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
        if (w_push && !w_pop)      r_fifoCount <= r_fifoCount + 1'b1;
        else if (w_pop && !w_push) r_fifoCount <= r_fifoCount - 1'b1;
      end
    end
  end

  // Trace storage; pointers alone define occupancy, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= {rvfi_pc_rdata, rvfi_insn};
    end
  end

endmodule

// File: tb/tb_core_step_controller.sv
module tb_core_step_controller;

  localparam logic [2:0] OP_NOP        = 3'd0;
  localparam logic [2:0] OP_RESET_CORE = 3'd1;
  localparam logic [2:0] OP_RUN        = 3'd2;
  localparam logic [2:0] OP_STEP       = 3'd3;
  localparam logic [2:0] OP_HALT       = 3'd4;
  localparam logic [2:0] OP_SET_BP     = 3'd5;
  localparam logic [2:0] OP_READ_TRACE = 3'd6;
  localparam logic [2:0] OP_STATUS     = 3'd7;
  localparam logic [31:0] ERR = 32'hFFFF_FFFF;
  localparam logic [31:0] NOBEAT = 32'hBAD0_BAD0;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_arg;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        clk_core_en;
  logic        reset_core;
  logic        rvfi_valid;
  logic        rvfi_trap;
  logic [31:0] rvfi_pc_rdata;
  logic [31:0] rvfi_insn;

  int compared;
  int mismatched;

  core_step_controller #(
    .CLK_FREQ    (25000000),
    .TRACE_DEPTH (4),
    .CYCLE_WIDTH (8),
    .RESET_CYCLES(16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_arg      (cmd_arg),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .clk_core_en  (clk_core_en),
    .reset_core   (reset_core),
    .rvfi_valid   (rvfi_valid),
    .rvfi_trap    (rvfi_trap),
    .rvfi_pc_rdata(rvfi_pc_rdata),
    .rvfi_insn    (rvfi_insn)
  );

  // Free-running 10 ns clock; inputs change and outputs are sampled on negedges.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Wait (bounded) for cmd_ready at a negedge.
  task automatic waitReady();
    int n;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      $display("[TB] FAIL cmd_ready_timeout: got 0 expected 1");
      mismatched++;
    end
    compared++;
  endtask

  // Issue one command and collect its beat(s) with rsp_ready held high.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] arg,
                               output logic [31:0] beat1, output logic [31:0] beat2);
    waitReady();
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    @(negedge clk);
    cmd_valid = 1'b0;
    beat1 = rsp_valid ? rsp_data : NOBEAT;
    beat2 = NOBEAT;
    if (op == OP_READ_TRACE) begin
      @(negedge clk);
      beat2 = rsp_valid ? rsp_data : NOBEAT;
    end
  endtask

  // One retirement on the RVFI port, returning at the negedge after it.
  task automatic applyRetire(input logic [31:0] pc, input logic [31:0] insn, input logic trap);
    rvfi_valid    = 1'b1;
    rvfi_pc_rdata = pc;
    rvfi_insn     = insn;
    rvfi_trap     = trap;
    @(negedge clk);
    rvfi_valid = 1'b0;
    rvfi_trap  = 1'b0;
  endtask

  task automatic test_reset();
    int hi;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    if (reset_core !== 1'b1 || clk_core_en !== 1'b1 || cmd_ready !== 1'b0) begin
      $display("[TB] FAIL in_reset_ctl: got rc=%b en=%b rdy=%b expected 1 1 0", reset_core, clk_core_en, cmd_ready);
      mismatched++;
    end
    compared++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'h0) begin
      $display("[TB] FAIL in_reset_rsp: got v=%b d=%h expected 0 00000000", rsp_valid, rsp_data);
      mismatched++;
    end
    compared++;
    reset = 1'b1;
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (reset_core === 1'b1) hi++;
      @(negedge clk);
    end
    if (hi != 16 || reset_core !== 1'b0) begin
      $display("[TB] FAIL reset_hold: got %0d cycles (now %b) expected 16 cycles then 0", hi, reset_core);
      mismatched++;
    end
    compared++;
  endtask

  task automatic test_status_after_reset();
    logic [31:0] b1, b2;
    applyStimulus(OP_STATUS, 32'h0, b1, b2);
    if (b1 !== 32'h0000_0001) begin
      $display("[TB] FAIL status_after_reset: got %h expected 00000001", b1);
      mismatched++;
    end
    compared++;
    applyStimulus(OP_NOP, 32'h1234, b1, b2);
    if (b1 !== 32'h0) begin
      $display("[TB] FAIL nop_rsp: got %h expected 00000000", b1);
      mismatched++;
    end
    compared++;
  endtask

  task automatic test_step();
    logic [31:0] b1, b2;
    int en;
    logic first;
    applyStimulus(OP_STEP, 32'd5, b1, b2);
    if (b1 !== 32'h0) begin
      $display("[TB] FAIL step5_rsp: got %h expected 00000000", b1);
      mismatched++;
    end
    compared++;
    en = 0;
    first = clk_core_en;
    for (int i = 0; i < 8; i++) begin
      if (clk_core_en === 1'b1) en++;
      @(negedge clk);
    end
    if (en != 5 || first !== 1'b1) begin
      $display("[TB] FAIL step5_cycles: got %0d (first %b) expected 5 (first 1)", en, first);
      mismatched++;
    end
    compared++;
    applyStimulus(OP_STATUS, 32'h0, b1, b2);
    if (b1 !== 32'h0000_0001) begin
      $display("[TB] FAIL step5_status: got %h expected 00000001", b1);
      mismatched++;
    end
    compared++;
    applyStimulus(OP_STEP, 32'd0, b1, b2);
    en = 0;
    for (int i = 0; i < 4; i++) begin
      if (clk_core_en === 1'b1) en++;
      @(negedge clk);
    end
    if (b1 !== 32'h0 || en != 0) begin
      $display("[TB] FAIL step0: got rsp %h en_cycles %0d expected 00000000 0", b1, en);
      mismatched++;
    end
    compared++;
    // Only the low 8 bits count: 0x103 steps three cycles.
    applyStimulus(OP_STEP, 32'h0000_0103, b1, b2);
    en = 0;
    for (int i = 0; i < 6; i++) begin
      if (clk_core_en === 1'b1) en++;
      @(negedge clk);
    end
    if (b1 !== 32'h0 || en != 3) begin
      $display("[TB] FAIL step_trunc: got rsp %h en_cycles %0d expected 00000000 3", b1, en);
      mismatched++;
    end
    compared++;
  endtask

  task automatic test_breakpoint();
    logic [31:0] b1, b2;
    applyStimulus(OP_SET_BP, 32'h0000_0010, b1, b2);
    if (b1 !== 32'h0) begin
      $display("[TB] FAIL setbp_rsp: got %h expected 00000000", b1);
      mismatched++;
    end
    compared++;
    applyStimulus(OP_RUN, 32'h0, b1, b2);
    if (b1 !== 32'h0 || clk_core_en !== 1'b1) begin
      $display("[TB] FAIL run_rsp: got rsp %h en %b expected 00000000 1", b1, clk_core_en);
      mismatched++;
    end
    compared++;
    applyRetire(32'h0000_000C, 32'h0000_0013, 1'b0);
    if (clk_core_en !== 1'b1) begin
      $display("[TB] FAIL bp_miss_runs: got %b expected 1", clk_core_en);
      mismatched++;
    end
    compared++;
    applyRetire(32'h0000_0010, 32'h0010_0093, 1'b0);
    if (clk_core_en !== 1'b0) begin
      $display("[TB] FAIL bp_hit_halts: got %b expected 0", clk_core_en);
      mismatched++;
    end
    compared++;
    applyStimulus(OP_STATUS, 32'h0, b1, b2);
    if (b1 !== 32'h0000_0205) begin
      $display("[TB] FAIL bp_status: got %h expected 00000205", b1);
      mismatched++;
    end
    compared++;
    applyStimulus(OP_STATUS, 32'h0, b1, b2);
    if (b1 !== 32'h0000_0201) begin
      $display("[TB] FAIL bp_status_cleared: got %h expected 00000201", b1);
      mismatched++;
    end
    compared++;
    applyStimulus(OP_READ_TRACE, 32'h0, b1, b2);
    if (b1 !== 32'h0000_000C || b2 !== 32'h0000_0013) begin
      $display("[TB] FAIL trace0: got %h %h expected 0000000c 00000013", b1, b2);
      mismatched++;
    end
    compared++;
    applyStimulus(OP_READ_TRACE, 32'h0, b1, b2);
    if (b1 !== 32'h0000_0010 || b2 !== 32'h0010_0093) begin
      $display("[TB] FAIL trace1: got %h %h expected 00000010 00100093", b1, b2);
      mismatched++;
    end
    compared++;
    applyStimulus(OP_SET_BP, ERR, b1, b2);
    if (b1 !== 32'h0) begin
      $display("[TB] FAIL bp_clear_rsp: got %h expected 00000000", b1);
      mismatched++;
    end
    compared++;
  endtask

  task automatic test_trap();
    logic [31:0] b1, b2;
    applyStimulus(OP_RUN, 32'h0, b1, b2);
    applyRetire(32'h0000_0020, 32'h0000_0073, 1'b1);
    if (clk_core_en !== 1'b0) begin
      $display("[TB] FAIL trap_halts: got %b expected 0", clk_core_en);
      mismatched++;
    end
    compared++;
    applyStimulus(OP_STATUS, 32'h0, b1, b2);
    if (b1 !== 32'h0000_0111) begin
      $display("[TB] FAIL trap_status: got %h expected 00000111", b1);
      mismatched++;
    end
    compared++;
    applyStimulus(OP_READ_TRACE, 32'h0, b1, b2);
    if (b1 !== 32'h0000_0020 || b2 !== 32'h0000_0073) begin
      $display("[TB] FAIL trap_trace: got %h %h expected 00000020 00000073", b1, b2);
      mismatched++;
    end
    compared++;
    // Breakpoint is disabled now, so retiring 0x10 must not halt.
    applyStimulus(OP_RUN, 32'h0, b1, b2);
    applyRetire(32'h0000_0010, 32'h0000_0001, 1'b0);
    if (clk_core_en !== 1'b1) begin
      $display("[TB] FAIL bp_disabled: got en %b expected 1", clk_core_en);
      mismatched++;
    end
    compared++;
    applyStimulus(OP_HALT, 32'h0, b1, b2);
    if (b1 !== 32'h0 || clk_core_en !== 1'b0) begin
      $display("[TB] FAIL halt: got rsp %h en %b expected 00000000 0", b1, clk_core_en);
      mismatched++;
    end
    compared++;
    applyStimulus(OP_HALT, 32'h0, b1, b2);
    if (b1 !== 32'h0) begin
      $display("[TB] FAIL halt_in_halted: got %h expected 00000000", b1);
      mismatched++;
    end
    compared++;
    applyStimulus(OP_READ_TRACE, 32'h0, b1, b2);
    applyStimulus(OP_STATUS, 32'h0, b1, b2);
    if (b1 !== 32'h0000_0001) begin
      $display("[TB] FAIL drained_status: got %h expected 00000001", b1);
      mismatched++;
    end
    compared++;
  endtask

  task automatic test_overflow();
    logic [31:0] b1, b2;
    for (int i = 0; i < 5; i++) begin
      applyRetire(32'h0000_0100 + 32'(4 * i), 32'h0000_00A0 + 32'(i), 1'b0);
    end
    applyStimulus(OP_STATUS, 32'h0, b1, b2);
    if (b1 !== 32'h0000_0409) begin
      $display("[TB] FAIL ovf_status: got %h expected 00000409", b1);
      mismatched++;
    end
    compared++;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(OP_READ_TRACE, 32'h0, b1, b2);
      if (b1 !== 32'h0000_0100 + 32'(4 * i) || b2 !== 32'h0000_00A0 + 32'(i)) begin
        $display("[TB] FAIL ovf_read%0d: got %h %h expected %h %h", i, b1, b2,
                 32'h0000_0100 + 32'(4 * i), 32'h0000_00A0 + 32'(i));
        mismatched++;
      end
      compared++;
    end
    applyStimulus(OP_READ_TRACE, 32'h0, b1, b2);
    if (b1 !== ERR || b2 !== ERR) begin
      $display("[TB] FAIL empty_read: got %h %h expected ffffffff ffffffff", b1, b2);
      mismatched++;
    end
    compared++;
    applyStimulus(OP_STATUS, 32'h0, b1, b2);
    if (b1 !== 32'h0000_0001) begin
      $display("[TB] FAIL ovf_cleared: got %h expected 00000001", b1);
      mismatched++;
    end
    compared++;
  endtask

  task automatic test_push_pop_full();
    logic [31:0] b1, b2;
    for (int i = 0; i < 4; i++) begin
      applyRetire(32'h0000_0200 + 32'(4 * i), 32'h0000_00B0 + 32'(i), 1'b0);
    end
    waitReady();
    cmd_valid     = 1'b1;
    cmd_op        = OP_READ_TRACE;
    cmd_arg       = 32'h0;
    rvfi_valid    = 1'b1;
    rvfi_pc_rdata = 32'h0000_0210;
    rvfi_insn     = 32'h0000_00B4;
    @(negedge clk);
    cmd_valid  = 1'b0;
    rvfi_valid = 1'b0;
    b1 = rsp_valid ? rsp_data : NOBEAT;
    @(negedge clk);
    b2 = rsp_valid ? rsp_data : NOBEAT;
    if (b1 !== 32'h0000_0200 || b2 !== 32'h0000_00B0) begin
      $display("[TB] FAIL pushpop_read: got %h %h expected 00000200 000000b0", b1, b2);
      mismatched++;
    end
    compared++;
    applyStimulus(OP_STATUS, 32'h0, b1, b2);
    if (b1 !== 32'h0000_0401) begin
      $display("[TB] FAIL pushpop_status: got %h expected 00000401", b1);
      mismatched++;
    end
    compared++;
    for (int i = 0; i < 3; i++) applyStimulus(OP_READ_TRACE, 32'h0, b1, b2);
    applyStimulus(OP_READ_TRACE, 32'h0, b1, b2);
    if (b1 !== 32'h0000_0210 || b2 !== 32'h0000_00B4) begin
      $display("[TB] FAIL pushpop_last: got %h %h expected 00000210 000000b4", b1, b2);
      mismatched++;
    end
    compared++;
  endtask

  task automatic test_errors_backpressure();
    logic [31:0] b1, b2;
    applyStimulus(OP_RUN, 32'h0, b1, b2);
    waitReady();
    rsp_ready = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = OP_STEP;
    cmd_arg   = 32'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (rsp_valid !== 1'b1 || rsp_data !== ERR || cmd_ready !== 1'b0) begin
        $display("[TB] FAIL hold%0d: got v=%b d=%h rdy=%b expected 1 ffffffff 0", i, rsp_valid, rsp_data, cmd_ready);
        mismatched++;
      end
      compared++;
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    if (rsp_valid !== 1'b0 || clk_core_en !== 1'b1) begin
      $display("[TB] FAIL hold_release: got v=%b en=%b expected 0 1", rsp_valid, clk_core_en);
      mismatched++;
    end
    compared++;
    applyStimulus(OP_SET_BP, 32'h40, b1, b2);
    if (b1 !== ERR) begin
      $display("[TB] FAIL setbp_running: got %h expected ffffffff", b1);
      mismatched++;
    end
    compared++;
    applyStimulus(OP_RUN, 32'h0, b1, b2);
    if (b1 !== ERR) begin
      $display("[TB] FAIL run_running: got %h expected ffffffff", b1);
      mismatched++;
    end
    compared++;
    applyStimulus(OP_STATUS, 32'h0, b1, b2);
    if (b1 !== 32'h0000_0002) begin
      $display("[TB] FAIL status_running: got %h expected 00000002", b1);
      mismatched++;
    end
    compared++;
  endtask

  task automatic test_reset_core();
    logic [31:0] b1, b2;
    int hi;
    applyStimulus(OP_RESET_CORE, 32'h0, b1, b2);
    if (b1 !== 32'h0) begin
      $display("[TB] FAIL resetcore_rsp: got %h expected 00000000", b1);
      mismatched++;
    end
    compared++;
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (reset_core === 1'b1) hi++;
      @(negedge clk);
    end
    if (hi != 16 || clk_core_en !== 1'b0) begin
      $display("[TB] FAIL resetcore_hold: got %0d cycles en %b expected 16 0", hi, clk_core_en);
      mismatched++;
    end
    compared++;
    applyStimulus(OP_STATUS, 32'h0, b1, b2);
    if (b1 !== 32'h0000_0001) begin
      $display("[TB] FAIL resetcore_status: got %h expected 00000001", b1);
      mismatched++;
    end
    compared++;
  endtask

  task automatic test_reset_mid_step();
    logic [31:0] b1, b2;
    waitReady();
    rsp_ready = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = OP_STEP;
    cmd_arg   = 32'd100;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || reset_core !== 1'b1 || cmd_ready !== 1'b0) begin
      $display("[TB] FAIL async_reset: got v=%b d=%h rc=%b rdy=%b expected 0 00000000 1 0",
               rsp_valid, rsp_data, reset_core, cmd_ready);
      mismatched++;
    end
    compared++;
    rsp_ready = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    if (reset_core !== 1'b0 || clk_core_en !== 1'b0 || rsp_valid !== 1'b0) begin
      $display("[TB] FAIL after_async_reset: got rc=%b en=%b v=%b expected 0 0 0", reset_core, clk_core_en, rsp_valid);
      mismatched++;
    end
    compared++;
    applyStimulus(OP_STATUS, 32'h0, b1, b2);
    if (b1 !== 32'h0000_0001) begin
      $display("[TB] FAIL after_reset_status: got %h expected 00000001", b1);
      mismatched++;
    end
    compared++;
  endtask

  initial begin
    compared      = 0;
    mismatched    = 0;
    reset         = 1'b0;
    cmd_valid     = 1'b0;
    cmd_op        = OP_NOP;
    cmd_arg       = 32'h0;
    rsp_ready     = 1'b1;
    rvfi_valid    = 1'b0;
    rvfi_trap     = 1'b0;
    rvfi_pc_rdata = 32'h0;
    rvfi_insn     = 32'h0;
    @(negedge clk);
    $display("[TB] starting core_step_controller tests");
    test_reset();
    test_status_after_reset();
    test_step();
    test_breakpoint();
    test_trap();
    test_overflow();
    test_push_pop_full();
    test_errors_backpressure();
    test_reset_core();
    test_reset_mid_step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/core_step_controller.md
CORE_STEP_CONTROLLER -- requirements
Module: core_step_controller

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 25000000, system clock frequency in Hz (informational only).
REQ-002 The block SHALL have parameter TRACE_DEPTH, default 16, trace FIFO entries (power of two, 2..256).
REQ-003 The block SHALL have parameter CYCLE_WIDTH, default 32, step-counter width (1..32).
REQ-004 The block SHALL have parameter RESET_CYCLES, default 16, reset_core hold length in clk cycles (≥1).
REQ-005 The block SHALL have port clk, input, 1, the single clock; all logic SHALL be on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port cmd_valid, input, 1, host command valid.
REQ-008 The block SHALL have port cmd_ready, output, 1, command accepted when high with cmd_valid.
REQ-009 The block SHALL have port cmd_op, input, 3, opcode: 0 NOP, 1 RESET_CORE, 2 RUN, 3 STEP, 4 HALT, 5 SET_BP, 6 READ_TRACE, 7 STATUS.
REQ-010 The block SHALL have port cmd_arg, input, 32, command argument.
REQ-011 The block SHALL have ports rsp_valid output 1, rsp_ready input 1, rsp_data output 32: response stream.
REQ-012 The block SHALL have port clk_core_en, output, 1, core clock-enable, driven to an external gating cell.
REQ-013 The block SHALL have port reset_core, output, 1, active-high core reset.
REQ-014 The block SHALL have ports rvfi_valid input 1, rvfi_trap input 1, rvfi_pc_rdata input 32, rvfi_insn input 32: core retirement trace.

Function
REQ-015 FSM states SHALL be RESETTING=0, HALTED=1, RUNNING=2, STEPPING=3.
REQ-016 cmd_ready SHALL be high iff state≠RESETTING and rsp_valid=0 and no second response beat is pending.
REQ-017 Every accepted command SHALL produce exactly one response beat the next cycle, except READ_TRACE (two beats, consecutive when rsp_ready=1).
REQ-018 rsp_data SHALL be held stable while rsp_valid=1 and rsp_ready=0; rsp_valid SHALL drop the cycle after the final beat is taken.
REQ-019 Success response SHALL be 0x0000_0000 for NOP, RESET_CORE, RUN, STEP, HALT, SET_BP; error response SHALL be 0xFFFF_FFFF.
REQ-020 RESETTING: reset_core=1, clk_core_en=1, for exactly RESET_CYCLES cycles, then HALTED with reset_core=0; trace FIFO and flags cleared on entry.
REQ-021 RESET_CORE SHALL be accepted in any non-RESETTING state and enter RESETTING; its response is issued on acceptance.
REQ-022 HALTED: clk_core_en=0; RUN enters RUNNING (clk_core_en=1 from the next cycle).
REQ-023 STEP with arg N>0 SHALL assert clk_core_en for exactly N cycles, starting the cycle after acceptance, then return to HALTED; N is truncated to CYCLE_WIDTH bits; N=0 SHALL be a no-op returning success.
REQ-024 HALT SHALL deassert clk_core_en the cycle after acceptance and enter HALTED; HALT in HALTED is a successful no-op.
REQ-025 In RUNNING/STEPPING, RUN, STEP and SET_BP SHALL return error with no state change; HALT, STATUS, READ_TRACE, NOP and RESET_CORE remain legal.
REQ-026 SET_BP SHALL load bp_addr=cmd_arg with bp_en=1; arg 0xFFFF_FFFF SHALL clear bp_en.
REQ-027 If bp_en and rvfi_valid and rvfi_pc_rdata==bp_addr in RUNNING/STEPPING, clk_core_en SHALL be 0 from the next cycle, state HALTED, sticky bp_hit=1.
REQ-028 rvfi_valid with rvfi_trap=1 in RUNNING/STEPPING SHALL halt identically and set sticky trap_hit=1.
REQ-029 A breakpoint/trap halt coinciding with the final STEP cycle, or with an accepted HALT, SHALL halt once, setting the flag.
REQ-030 Every rvfi_valid cycle outside RESETTING SHALL push {pc, insn}; when full the new entry SHALL be dropped and sticky overflow=1.
REQ-031 Simultaneous push and pop when full SHALL succeed without overflow.
REQ-032 READ_TRACE SHALL return pc then insn of the oldest entry and pop it; when empty both beats SHALL be 0xFFFF_FFFF.
REQ-033 STATUS SHALL return {16'b0, count[7:0], 3'b0, trap_hit, overflow, bp_hit, state[1:0]}, then clear bp_hit, trap_hit, overflow.

Reset
REQ-034 reset=0 SHALL asynchronously force: state RESETTING with counter restarted, reset_core=1, clk_core_en=1, cmd_ready=0, rsp_valid=0, rsp_data=0, FIFO empty, flags 0, bp_en=0, bp_addr=0.
REQ-035 reset asserted mid-STEP or mid-response SHALL abandon the operation; no pending beat survives.

Verification
REQ-036 Release reset -> reset_core=1 for 16 cycles, then 0; STATUS returns 0x0000_0001.
REQ-037 STEP arg=5 -> clk_core_en high exactly 5 cycles, then STATUS state=1; STEP arg=0 -> response 0, clk_core_en stays 0.
REQ-038 SET_BP 0x0000_0010, RUN, retire pc 0x0C then 0x10 -> clk_core_en 0 the cycle after 0x10 retires; STATUS = 0x0000_0205 (count=2, bp_hit, HALTED).
REQ-039 TRACE_DEPTH=4, 5 retirements -> STATUS overflow=1, count=4; 4 READ_TRACE yield first 4 pc/insn pairs; 5th yields 0xFFFF_FFFF twice.
REQ-040 RUN then STEP 3 -> 0xFFFF_FFFF response, still RUNNING; hold rsp_ready=0 for 3 cycles -> rsp_data stable, cmd_ready=0.
